// File: rtl/icache_fetch_if.sv
// Fetch-side and memory-side handshake bundle for icache_fetch.
// Latency: none, this is wiring only.
// Backpressure: the fetcher holds if_read_signal until if_success; the cache holds icache_read_signal until icache_success.
interface icache_fetch_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  if_read_signal;
    logic [ADDR_WIDTH-1:0] if_pc;
    logic [31:0]           if_instr;
    logic                  if_success;
    logic                  icache_read_signal;
    logic [ADDR_WIDTH-1:0] icache_addr;
    logic [31:0]           icache_read_instr;
    logic                  icache_success;

    modport master (
        output if_read_signal, if_pc, icache_read_instr, icache_success,
        input  if_instr, if_success, icache_read_signal, icache_addr
    );

    modport slave (
        input  if_read_signal, if_pc, icache_read_instr, icache_success,
        output if_instr, if_success, icache_read_signal, icache_addr
    );
endinterface

// File: rtl/icache_fetch.sv
// Direct-mapped one-word-per-line icache; ICACHE_PERF_CNT_EN adds hit/miss counters.
// Latency: hit 1 cycle, miss = memory latency + 1, then one COOLDOWN cycle.
// Backpressure: rdy=0 freezes everything; jump_wrong aborts any outstanding miss.
module icache_fetch #(
    parameter int INDEX_WIDTH = 8,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        jump_wrong,
    icache_fetch_if.slave bus
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    localparam int LINES = 1 << INDEX_WIDTH;
    localparam int TAG_W = ADDR_WIDTH - INDEX_WIDTH - 2;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_MISS_WAIT = 2'd1;
    localparam logic [1:0] ST_COOLDOWN  = 2'd2;

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] miss_addr;
    logic [LINES-1:0]      valid_bits;
    logic [TAG_W-1:0]      tag_mem  [LINES];
    logic [31:0]           data_mem [LINES];

    logic [INDEX_WIDTH-1:0] req_idx;
    logic [TAG_W-1:0]       req_tag;
    logic [INDEX_WIDTH-1:0] miss_idx;
    logic [TAG_W-1:0]       miss_tag;
    logic                   hit;
    logic                   fill;
    logic                   unused_bits;

    assign req_idx  = bus.if_pc[INDEX_WIDTH+1:2];
    assign req_tag  = bus.if_pc[ADDR_WIDTH-1:INDEX_WIDTH+2];
    assign miss_idx = miss_addr[INDEX_WIDTH+1:2];
    assign miss_tag = miss_addr[ADDR_WIDTH-1:INDEX_WIDTH+2];
    assign hit      = valid_bits[req_idx] && (tag_mem[req_idx] == req_tag);
    // A fill coinciding with a flush is dropped along with its data.
    assign fill     = rdy && !jump_wrong && (state == ST_MISS_WAIT) && bus.icache_success;

    assign bus.icache_addr = miss_addr;
    assign unused_bits     = ^{bus.if_pc[1:0], miss_addr[1:0]};

    always_ff @(posedge clk) begin
        if (!rst && fill) begin
            tag_mem[miss_idx]  <= miss_tag;
            data_mem[miss_idx] <= bus.icache_read_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                  <= ST_IDLE;
            valid_bits             <= '0;
            miss_addr              <= '0;
            bus.if_success         <= 1'b0;
            bus.if_instr           <= '0;
            bus.icache_read_signal <= 1'b0;
`ifdef ICACHE_PERF_CNT_EN
            hit_count              <= '0;
            miss_count             <= '0;
`endif
        end else if (rdy) begin
            bus.if_success <= 1'b0;
            if (jump_wrong) begin
                state                  <= ST_IDLE;
                bus.icache_read_signal <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.if_read_signal) begin
                            if (hit) begin
                                bus.if_success <= 1'b1;
                                bus.if_instr   <= data_mem[req_idx];
`ifdef ICACHE_PERF_CNT_EN
                                hit_count      <= hit_count + 32'd1;
`endif
                            end else begin
                                miss_addr              <= bus.if_pc;
                                bus.icache_read_signal <= 1'b1;
                                state                  <= ST_MISS_WAIT;
`ifdef ICACHE_PERF_CNT_EN
                                miss_count             <= miss_count + 32'd1;
`endif
                            end
                        end
                    end
                    ST_MISS_WAIT: begin
                        if (bus.icache_success) begin
                            valid_bits[miss_idx]   <= 1'b1;
                            bus.icache_read_signal <= 1'b0;
                            bus.if_success         <= 1'b1;
                            bus.if_instr           <= bus.icache_read_instr;
                            state                  <= ST_COOLDOWN;
                        end
                    end
                    // Gives the memory controller a low cycle to re-arm.
                    ST_COOLDOWN: state <= ST_IDLE;
                    default:     state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_icache_fetch.sv
// Scoreboard bench for icache_fetch: driver pushes expectations, monitor pops on if_success.
// Latency: hit latency checked in rdy-stable phases; memory responder has programmable delay.
// Backpressure: random rdy stalls and flushes, with a responder that re-pulses ignored answers.
module tb_icache_fetch;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    logic jump_wrong;
    icache_fetch_if #(.ADDR_WIDTH(AW)) bus ();
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    icache_fetch #(.INDEX_WIDTH(8), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .jump_wrong (jump_wrong),
        .bus        (bus)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        bit          hit;
        int          id;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] line_pc [int];
    int          total   = 0;
    int          bad     = 0;
    int          mem_lat = 4;
    int          next_id = 0;
    bit          done    = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0413;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: event seen that must not occur", name);
    endtask

    // Memory controller model: answers mem_lat cycles after the request is seen.
    initial begin
        int cnt = 0;
        bus.icache_success    = 1'b0;
        bus.icache_read_instr = '0;
        forever begin
            @(negedge clk);
            if (bus.icache_success) begin
                bus.icache_success = 1'b0;
                cnt = 0;
            end else if (bus.icache_read_signal === 1'b1) begin
                cnt++;
                if (cnt >= mem_lat) begin
                    bus.icache_success    = 1'b1;
                    bus.icache_read_instr = mem_word(bus.icache_addr);
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: compares DUT responses against queued expectations.
    initial begin
        int   saw_id   = -1;
        bit   chk_cool = 0;
        exp_t e;
        while (!done) begin
            @(posedge clk);
            #1;
            if (rst) begin
                saw_id   = -1;
                chk_cool = 0;
            end else begin
                if (chk_cool) begin
                    chk_cool = 0;
                    check("cooldown_read_low", 32'(bus.icache_read_signal), 32'd0);
                end
                if (bus.icache_read_signal) begin
                    if (exp_q.size() == 0) fail("read_without_fetch");
                    else begin
                        check("icache_addr", bus.icache_addr, exp_q[0].pc);
                        if (exp_q[0].hit) fail("read_on_predicted_hit");
                        saw_id = exp_q[0].id;
                    end
                end
                if (bus.if_success && rdy) begin
                    if (exp_q.size() == 0) fail("unexpected_success");
                    else begin
                        e = exp_q.pop_front();
                        check("if_instr", bus.if_instr, e.data);
                        check("miss_read_issued", 32'(saw_id == e.id), 32'(!e.hit));
                        if (!e.hit) begin
                            check("read_dropped_on_fill", 32'(bus.icache_read_signal), 32'd0);
                            chk_cool = 1;
                        end
                    end
                end
            end
        end
    end

    // flush_mode: 0 none, 1 random flush, 2 flush together with icache_success.
    task automatic fetch(input logic [31:0] pc, input bit rand_rdy, input int flush_mode,
                         input bit stall, input bit check_lat);
        exp_t e;
        int   ix = int'(pc[9:2]);
        int   waited = 0;
        int   stall_left = 0;
        bit   stalled = 0;
        bit   fin = 0;
        bit   do_flush;
        e.pc   = pc;
        e.data = mem_word(pc);
        e.hit  = line_pc.exists(ix) && (line_pc[ix] == pc);
        e.id   = next_id++;
        exp_q.push_back(e);
        bus.if_read_signal = 1'b1;
        bus.if_pc          = pc;
        rdy = rand_rdy ? ($urandom_range(0, 4) != 0) : 1'b1;
        while (!fin) begin
            @(negedge clk);
            #1;
            waited++;
            jump_wrong = 1'b0;
            do_flush   = 1'b0;
            if (bus.if_success && rdy) begin
                fin = 1;
                bus.if_read_signal = 1'b0;
                if (!e.hit) line_pc[ix] = pc;
                if (check_lat && e.hit) check("hit_latency", 32'(waited), 32'd1);
            end else if (waited > 300) begin
                fail("fetch_timeout");
                do_flush = 1'b1;
            end else if (flush_mode == 2 && bus.icache_success) begin
                do_flush = 1'b1;
            end else if (flush_mode == 1 && $urandom_range(0, 39) == 0) begin
                do_flush = 1'b1;
            end else begin
                if (stall && !stalled && bus.icache_read_signal) begin
                    stalled    = 1;
                    stall_left = 3;
                end
                if (stall_left > 0) begin
                    rdy = 1'b0;
                    stall_left--;
                end else begin
                    rdy = rand_rdy ? ($urandom_range(0, 4) != 0) : 1'b1;
                end
            end
            if (do_flush) begin
                fin = 1;
                bus.if_read_signal = 1'b0;
                jump_wrong = 1'b1;
                rdy = 1'b1;
                @(negedge clk);
                #1;
                jump_wrong = 1'b0;
                if (exp_q.size() > 0 && exp_q[$].id == e.id) void'(exp_q.pop_back());
            end
        end
        rdy = rand_rdy ? ($urandom_range(0, 4) != 0) : 1'b1;
        @(negedge clk);
        #1;
        rdy = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        line_pc.delete();
        check("rst_if_success", 32'(bus.if_success), 32'd0);
        check("rst_if_instr", bus.if_instr, 32'd0);
        check("rst_read_signal", 32'(bus.icache_read_signal), 32'd0);
        check("rst_icache_addr", bus.icache_addr, 32'd0);
`ifdef ICACHE_PERF_CNT_EN
        check("rst_hit_count", hit_count, 32'd0);
        check("rst_miss_count", miss_count, 32'd0);
`endif
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] pc;
        rst = 1'b1;
        rdy = 1'b1;
        jump_wrong = 1'b0;
        bus.if_read_signal = 1'b0;
        bus.if_pc = '0;
        @(negedge clk);
        #1;
        do_reset();

        mem_lat = 4;
        fetch(32'h0000_0000, 0, 0, 0, 1);
        fetch(32'h0000_0000, 0, 0, 0, 1);
        fetch(32'h0000_0400, 0, 0, 0, 1);
        fetch(32'h0000_0000, 0, 0, 0, 1);
        fetch(32'h0000_0010, 0, 2, 0, 1);
        fetch(32'h0000_0010, 0, 0, 0, 1);
        fetch(32'h0000_0020, 0, 0, 1, 1);
        fetch(32'h0000_0020, 0, 0, 0, 1);
        fetch(32'hFFFF_FFFC, 0, 0, 0, 1);
        fetch(32'hFFFF_FFFC, 0, 0, 0, 1);

        for (int i = 0; i < 300; i++) begin
            mem_lat = $urandom_range(1, 5);
            if ($urandom_range(0, 15) == 0) pc = 32'hFFFF_FFFC;
            else pc = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 2);
            fetch(pc, 1, 1, 0, 0);
        end

        mem_lat = 3;
        do_reset();
        fetch(32'h0000_0000, 0, 0, 0, 1);

`ifdef ICACHE_PERF_CNT_EN
        do_reset();
        fetch(32'h0000_0100, 0, 0, 0, 1);
        fetch(32'h0000_0104, 0, 0, 0, 1);
        fetch(32'h0000_0108, 0, 0, 0, 1);
        fetch(32'h0000_0100, 0, 0, 0, 1);
        fetch(32'h0000_0104, 0, 0, 0, 1);
        fetch(32'h0000_0108, 0, 0, 0, 1);
        fetch(32'h0000_0100, 0, 0, 0, 1);
        fetch(32'h0000_0104, 0, 0, 0, 1);
        check("hit_count", hit_count, 32'd5);
        check("miss_count", miss_count, 32'd3);
        do_reset();
`endif

        repeat (5) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        done = 1;
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/icache_fetch.md
Name: icache_fetch

Overview:
- Direct-mapped, one-word-per-line instruction cache between the instruction fetcher and the memory controller's icache port.
- Serves fetch PCs from local storage on hit.
- On miss, acts as initiator on the controller's icache read handshake, fills the line and returns the word.
- Fetch redirects from the ROB abort any outstanding miss.

Parameters:
- INDEX_WIDTH, 8, log2 of line count (256 lines); index = pc[INDEX_WIDTH+1:2].
- ADDR_WIDTH, 32, PC width; tag = pc[ADDR_WIDTH-1:INDEX_WIDTH+2].

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- rdy  input  1  global enable; low freezes all state
- jump_wrong  input  1  ROB misprediction flush
- if_read_signal  input  1  fetcher requests instruction at if_pc
- if_pc  input  ADDR_WIDTH  fetch address, word aligned
- if_instr  output  32  returned instruction
- if_success  output  1  one-cycle pulse, if_instr valid
- icache_read_signal  output  1  level request to memory controller
- icache_addr  output  ADDR_WIDTH  address of requested word
- icache_read_instr  input  32  word from memory controller
- icache_success  input  1  one-cycle pulse, icache_read_instr valid

Behaviour:
- Reset, and every output's reset value:
  - All valid bits cleared; state IDLE.
  - if_success=0, if_instr=0, icache_read_signal=0, icache_addr=0.
  - Reset has priority over jump_wrong and rdy.
- rdy=0: no register changes, outputs hold; success pulses arriving then are ignored.
- Storage: valid[2^INDEX_WIDTH], tag array, 32-bit data array; registered writes.
- State IDLE:
  - if_read_signal=1 and hit (valid & tag match) -> next cycle if_success=1, if_instr=data. Hit latency is 1 cycle.
  - if_read_signal=1 and miss -> latch pc into miss_addr; next cycle icache_read_signal=1, icache_addr=miss_addr; go MISS_WAIT.
  - No request -> if_success=0.
- State MISS_WAIT:
  - icache_read_signal and icache_addr are held constant until icache_success.
  - On icache_success: write valid/tag/data at miss_addr index (overwrite, no victim handling).
  - Same edge: drop icache_read_signal to 0, set if_success=1 for one cycle, set if_instr=icache_read_instr; go COOLDOWN.
  - Miss latency = memory latency + 1 cycle.
- State COOLDOWN: one cycle with icache_read_signal=0, so the controller re-arms for the next address; then IDLE.
  - A request present in this cycle is not accepted; the fetcher keeps if_read_signal high and it is served from IDLE.
- if_success is a single-cycle pulse in all cases; if_instr holds its last value otherwise.
- if_read_signal changing during MISS_WAIT is ignored; the miss completes for miss_addr.
- jump_wrong=1:
  - Any state -> IDLE next cycle; icache_read_signal=0, if_success=0.
  - A coincident icache_success is discarded: no array write, no if_success.
  - Valid bits are not cleared.
  - A request presented in the same cycle as jump_wrong is not accepted.
- Index aliasing: two PCs with the same index evict each other; each access to the other PC is a miss.
- Wrap-around: PC near the top of the address space needs no special handling (single word per line).

Optional Feature:
- Macro ICACHE_PERF_CNT_EN.
- Defined: adds outputs hit_count[31:0] and miss_count[31:0].
  - hit_count increments on each hit-served if_success.
  - miss_count increments on each miss acceptance into MISS_WAIT.
  - Both wrap modulo 2^32, are cleared by rst, and are not cleared by jump_wrong.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Cold miss:
  - Stimulus: after reset, if_pc=0x0000_0000; memory model answers 4 cycles after request with 0x0000_0413.
  - Required: icache_read_signal=1 with icache_addr=0x0; if_success pulses once with if_instr=0x0000_0413; icache_read_signal low in the following cycle.
- Hit:
  - Stimulus: re-fetch 0x0000_0000.
  - Required: if_success one cycle after the request, if_instr=0x0000_0413; icache_read_signal stays 0.
- Conflict:
  - Stimulus: with INDEX_WIDTH=8, fetch 0x0000_0400 (same index as 0x0), then 0x0.
  - Required: both fetches miss; data returned matches the memory model.
- Flush mid-miss:
  - Stimulus: miss on 0x0000_0010, jump_wrong in the same cycle as icache_success.
  - Required: no if_success; a later fetch of 0x10 misses again.
- rdy stall:
  - Stimulus: hold rdy=0 for 3 cycles during MISS_WAIT, with icache_success pulsed only after rdy returns.
  - Required: icache_addr stable throughout; a single correct if_success.
- Perf counters (ICACHE_PERF_CNT_EN defined):
  - Stimulus: sequence of 3 misses and 5 hits.
  - Required: hit_count=5, miss_count=3; both 0 after rst.
